// File: rtl/mul256_seq_pkg.sv
// Shared types and constants for the mul256_op command sequencer.
// Holds the FSM state enum, engine register offsets and bit indices.
package mul256_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_POLL,
        S_STATUS,
        S_FINISH
    } seq_state_t;

    localparam logic [31:0] CTRL_OFS = 32'd0;
    localparam logic [31:0] STAT_OFS = 32'd4;

    localparam int VALID_BIT = 31;
    localparam int END_BIT   = 30;
    localparam int BUSY_BIT  = 31;

endpackage

// File: rtl/mul256_seq_prog_ram.sv
// Program store: 2**AW x 32, one write port, one synchronous read port.
// Ports: i_clk, i_we/i_waddr/i_wdata (write), i_raddr -> o_rdata (1-cycle).
module mul256_seq_prog_ram #(
    parameter int AW = 6
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    // No reset: program contents must survive a sequencer reset.
    logic [31:0] r_mem [2**AW];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/mul256_op_seq.sv
// Command sequencer: issues program words to the mul256_op engine over
// Avalon-MM, polls busy, then reads the compare status.
// Ports: hclk/reset, prog_* (program load), start/start_pc/abort (control),
// busy/done/err/aborted/cmp_result (status), amm_* (Avalon-MM master).
module mul256_op_seq #(
    parameter int          PROG_AW  = 6,
    parameter logic [31:0] BASE     = 32'h0000_1000,
    parameter int          POLL_MAX = 1024
) (
    input  logic               hclk,
    input  logic               reset,
    input  logic               prog_we,
    input  logic [PROG_AW-1:0] prog_addr,
    input  logic [31:0]        prog_wdata,
    input  logic               start,
    input  logic [PROG_AW-1:0] start_pc,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               aborted,
    output logic [1:0]         cmp_result,
    output logic [31:0]        amm_address,
    output logic [31:0]        amm_writedata,
    output logic               amm_write,
    output logic               amm_read,
    input  logic [31:0]        amm_readdata,
    input  logic               amm_waitrequest
);

    import mul256_seq_pkg::*;

    localparam int                 PCW     = $clog2(POLL_MAX + 1);
    localparam logic [PCW-1:0]     PMAX    = PCW'(POLL_MAX);
    localparam logic [PROG_AW-1:0] PC_LAST = '1;

    seq_state_t         r_state, w_state;
    logic [PROG_AW-1:0] r_pc, w_pc;
    logic [PCW-1:0]     r_poll, w_poll;
    logic [PCW-1:0]     w_poll_inc;
    logic               r_end, w_end;
    logic               r_busy, w_busy;
    logic               r_done, w_done;
    logic               r_err, w_err;
    logic               r_aborted, w_aborted;
    logic [1:0]         r_cmp, w_cmp;
    logic               r_wr, w_wr;
    logic               r_rd, w_rd;
    logic [31:0]        r_addr, w_addr;
    logic [31:0]        r_wdata, w_wdata;
    logic               w_xfer_ok;
    logic               w_abort_now;
    logic [31:0]        w_word;
    logic               w_unused;

    // Read address follows the next pc so the word is valid during FETCH.
    mul256_seq_prog_ram #(
        .AW (PROG_AW)
    ) u_ram (
        .i_clk   (hclk),
        .i_we    (prog_we & ~r_busy),
        .i_waddr (prog_addr),
        .i_wdata (prog_wdata),
        .i_raddr (w_pc),
        .o_rdata (w_word)
    );

    assign w_unused   = ^{amm_readdata[30:1], w_word[31]};
    assign w_xfer_ok  = (r_wr | r_rd) & ~amm_waitrequest;
    assign w_poll_inc = r_poll + 1'b1;

    always_comb begin
        w_state     = r_state;
        w_pc        = r_pc;
        w_poll      = r_poll;
        w_end       = r_end;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_aborted   = 1'b0;
        w_cmp       = r_cmp;
        w_wr        = r_wr;
        w_rd        = r_rd;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_abort_now = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state = S_FETCH;
                    w_pc    = start_pc;
                    w_poll  = '0;
                    w_busy  = 1'b1;
                end
            end
            S_FETCH: begin
                if (abort) begin
                    w_abort_now = 1'b1;
                end else begin
                    w_state = S_WRITE;
                    w_end   = w_word[END_BIT];
                    w_wr    = 1'b1;
                    w_addr  = BASE + CTRL_OFS;
                    w_wdata = {1'b1, 1'b0, w_word[29:0]};
                end
            end
            S_WRITE: begin
                if (w_xfer_ok) begin
                    w_wr = 1'b0;
                    if (abort) begin
                        w_abort_now = 1'b1;
                    end else begin
                        w_state = S_POLL;
                        w_rd    = 1'b1;
                        w_addr  = BASE + CTRL_OFS;
                    end
                end
            end
            S_POLL: begin
                if (w_xfer_ok) begin
                    if (abort) begin
                        w_abort_now = 1'b1;
                    end else if (amm_readdata[BUSY_BIT]) begin
                        // Read stays asserted: next cycle is a fresh poll.
                        w_poll = w_poll_inc;
                        if (w_poll_inc == PMAX) begin
                            w_poll  = '0;
                            w_err   = 1'b1;
                            w_busy  = 1'b0;
                            w_rd    = 1'b0;
                            w_state = S_IDLE;
                        end
                    end else begin
                        w_poll = '0;
                        if (r_end || r_pc == PC_LAST) begin
                            w_state = S_STATUS;
                            w_addr  = BASE + STAT_OFS;
                        end else begin
                            w_rd    = 1'b0;
                            w_pc    = r_pc + 1'b1;
                            w_state = S_FETCH;
                        end
                    end
                end
            end
            S_STATUS: begin
                if (w_xfer_ok) begin
                    w_rd = 1'b0;
                    if (abort) begin
                        w_abort_now = 1'b1;
                    end else begin
                        w_cmp   = {amm_readdata[31], amm_readdata[0]};
                        w_done  = 1'b1;
                        w_busy  = 1'b0;
                        w_state = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                w_state   = S_IDLE;
                w_aborted = abort;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        if (w_abort_now) begin
            w_state   = S_IDLE;
            w_busy    = 1'b0;
            w_aborted = 1'b1;
            w_wr      = 1'b0;
            w_rd      = 1'b0;
        end
    end

    always_ff @(posedge hclk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_poll    <= '0;
            r_end     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_aborted <= 1'b0;
            r_cmp     <= 2'b00;
            r_wr      <= 1'b0;
            r_rd      <= 1'b0;
            r_addr    <= BASE;
            r_wdata   <= '0;
        end else begin
            r_state   <= w_state;
            r_pc      <= w_pc;
            r_poll    <= w_poll;
            r_end     <= w_end;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_err     <= w_err;
            r_aborted <= w_aborted;
            r_cmp     <= w_cmp;
            r_wr      <= w_wr;
            r_rd      <= w_rd;
            r_addr    <= w_addr;
            r_wdata   <= w_wdata;
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign aborted       = r_aborted;
    assign cmp_result    = r_cmp;
    assign amm_address   = r_addr;
    assign amm_writedata = r_wdata;
    assign amm_write     = r_wr;
    assign amm_read      = r_rd;

endmodule
